// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer slice.
//   sb_entry_t       : one buffered store (valid flag, byte address, data word)
//   SB_DEPTH_DEFAULT : default number of buffered stores
//   SB_ADDR_W/DATA_W : address and data widths that the entry type is built from
//   word_match()     : word-granular address compare (byte offset bits ignored)
package sb_pkg;

    localparam int SB_DEPTH_DEFAULT = 4;
    localparam int SB_ADDR_W        = 32;
    localparam int SB_DATA_W        = 32;

    typedef struct packed {
        logic                 valid;
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

    // Two byte addresses hit the same word when everything above the byte offset agrees.
    function automatic logic word_match(input logic [SB_ADDR_W-1:0] a,
                                        input logic [SB_ADDR_W-1:0] b);
        return (a[SB_ADDR_W-1:2] == b[SB_ADDR_W-1:2]);
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Bundle of the datapath load/store path and the data_mem port seen by the store buffer.
//   master : datapath + data_mem side (drives requests and mem_rd)
//   slave  : store buffer side (drives st_ready, ld_data and the memory write port)
interface store_buffer_if
    import sb_pkg::*;
#(
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
);
    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_ready;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_rd;

    modport master (
        output st_valid, st_addr, st_data, ld_en, ld_addr, mem_rd,
        input  st_ready, ld_data, mem_we, mem_a, mem_wd
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_en, ld_addr, mem_rd,
        output st_ready, ld_data, mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/store_buffer_fwd_match.sv
// Combinational youngest-match search over the buffered stores.
//   entries  : FIFO storage
//   head     : index of the oldest pending store
//   count    : number of pending stores
//   ld_addr  : load byte address
//   hit      : some pending store targets the load's word
//   hit_data : data of the youngest such store
module sb_fwd_match
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT
) (
    input  sb_entry_t                    entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]     head,
    input  logic [$clog2(DEPTH):0]       count,
    input  logic [SB_ADDR_W-1:0]         ld_addr,
    output logic                         hit,
    output logic [SB_DATA_W-1:0]         hit_data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] idx_s;

    // Walk oldest -> youngest from head (wrapping); a later match overrides an earlier one,
    // so the surviving hit is the entry closest to tail.
    always_comb begin
        hit      = 1'b0;
        hit_data = {SB_DATA_W{1'b0}};
        idx_s    = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx_s = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && entries[idx_s].valid &&
                word_match(entries[idx_s].addr, ld_addr)) begin
                hit      = 1'b1;
                hit_data = entries[idx_s].data;
            end else begin
                hit      = hit;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer in front of data_mem: posts stores into a small FIFO, retires one per cycle
// whenever a load is not using the memory port, and forwards the youngest matching pending
// store to loads.
//   clk, reset : clock and synchronous active-high reset
//   bus        : load/store requests and data_mem port (slave side)
//   empty      : no stores pending (registered)
//   count      : number of stores pending (registered)
// Entry storage uses sb_entry_t, so ADDR_W/DATA_W are expected to stay at the package widths.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH_DEFAULT,
    parameter int DATA_W = SB_DATA_W,
    parameter int ADDR_W = SB_ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    store_buffer_if.slave          bus,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int                PTR_W    = $clog2(DEPTH);
    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    sb_entry_t          entries_r [DEPTH];
    logic [PTR_W-1:0]   head_r;
    logic [PTR_W-1:0]   tail_r;
    logic [CNT_W-1:0]   count_r;
    logic               empty_r;
    logic [CNT_W-1:0]   count_nxt_s;
    logic               enq_s;
    logic               drain_s;
    logic               hit_s;
    logic [DATA_W-1:0]  hit_data_s;

    // A full buffer refuses stores even if it drains this cycle (no pass-through).
    assign enq_s   = bus.st_valid && (count_r < FULL_CNT);
    // Loads own the port; the head only retires on cycles without a load.
    assign drain_s = !reset && !bus.ld_en && !empty_r;

    assign bus.st_ready = reset || (count_r < FULL_CNT);
    assign empty        = empty_r;
    assign count        = count_r;

    // Memory port arbitration: load address, head write, or an idle all-zero port.
    always_comb begin
        bus.mem_we = 1'b0;
        bus.mem_a  = {ADDR_W{1'b0}};
        bus.mem_wd = {DATA_W{1'b0}};
        if (reset) begin
            bus.mem_we = 1'b0;
        end else if (bus.ld_en) begin
            bus.mem_a = bus.ld_addr;
        end else if (!empty_r) begin
            bus.mem_we = 1'b1;
            bus.mem_a  = entries_r[head_r].addr;
            bus.mem_wd = entries_r[head_r].data;
        end else begin
            bus.mem_we = 1'b0;
        end
    end

    sb_fwd_match #(.DEPTH(DEPTH)) u_fwd (
        .entries  (entries_r),
        .head     (head_r),
        .count    (count_r),
        .ld_addr  (bus.ld_addr),
        .hit      (hit_s),
        .hit_data (hit_data_s)
    );

    // Load result: pending store data wins over the (stale) memory contents.
    always_comb begin
        if (hit_s) begin
            bus.ld_data = hit_data_s;
        end else begin
            bus.ld_data = bus.mem_rd;
        end
    end

    // Next occupancy: enqueue and drain together leave it unchanged.
    always_comb begin
        case ({enq_s, drain_s})
            2'b10:   count_nxt_s = count_r + 1'b1;
            2'b01:   count_nxt_s = count_r - 1'b1;
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO storage, pointers and occupancy; reset drops every pending store.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            empty_r <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i] <= '{valid: 1'b0, addr: {SB_ADDR_W{1'b0}}, data: {SB_DATA_W{1'b0}}};
            end
        end else begin
            // Head and tail never coincide here: drain needs count>0, enqueue needs count<DEPTH.
            if (drain_s) begin
                entries_r[head_r].valid <= 1'b0;
                head_r                  <= head_r + 1'b1;
            end
            if (enq_s) begin
                entries_r[tail_r] <= '{valid: 1'b1, addr: bus.st_addr, data: bus.st_data};
                tail_r            <= tail_r + 1'b1;
            end
            count_r <= count_nxt_s;
            empty_r <= (count_nxt_s == {CNT_W{1'b0}});
        end
    end

endmodule
